// File: rtl/shift_pkg.sv
// Shared definitions for the execute-stage shift unit: funct codes, buffer FSM states
// and the shift-kind selector consumed by shift_core.
package shift_pkg;

  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_SRA  = 6'h03;
  localparam logic [5:0] FUNCT_SLLV = 6'h04;
  localparam logic [5:0] FUNCT_SRLV = 6'h06;
  localparam logic [5:0] FUNCT_SRAV = 6'h07;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    LEFT          = 2'd0,
    RIGHT_LOGICAL = 2'd1,
    RIGHT_ARITH   = 2'd2,
    ROTATE        = 2'd3
  } shift_kind_t;

endpackage

// File: rtl/shift_core.sv
// Combinational 5-level logarithmic shifter: each level shifts by 2^i when amt[i] is set.
module shift_core
  import shift_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] data,
  input  logic [4:0]      amt,
  input  shift_kind_t     kind,
  output logic [XLEN-1:0] res
);

  logic signed [XLEN-1:0] stage;

  always_comb begin
    stage = data;
    for (int i = 0; i < 5; i++) begin
      if (amt[i]) begin
        case (kind)
          LEFT:          stage = stage << (1 << i);
          RIGHT_LOGICAL: stage = stage >> (1 << i);
          RIGHT_ARITH:   stage = stage >>> (1 << i);
          default:       stage = (stage >> (1 << i)) | (stage << (XLEN - (1 << i)));
        endcase
      end
    end
  end

  assign res = stage;

endmodule

// File: rtl/shift_ex_stage.sv
// MIPS EX-stage shift unit: funct decode, amount select, shift, 2-entry skid buffer to EX/MEM.
// Optional rotate forms (ROTR/ROTRV) are enabled by defining SHIFT_ROTATE_EN.
module shift_ex_stage
  import shift_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [5:0]      in_funct,
  input  logic [4:0]      in_shamt,
  input  logic            in_r,
  input  logic [XLEN-1:0] in_rs,
  input  logic [XLEN-1:0] in_rt,
  input  logic [RD_W-1:0] in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [RD_W-1:0] out_rd,
  output logic            out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0] res;
    logic [RD_W-1:0] rd;
    logic            ill;
  } entry_t;

  shift_kind_t     kind_p0;
  logic [4:0]      amt_p0;
  logic            legal_p0;
  logic [XLEN-1:0] core_res_p0;
  entry_t          new_p0;
  entry_t          head_p1;
  entry_t          skid_p1;
  state_t          state;
  logic            accept;
  logic            pop;
  logic            unused_ok;

  // in_rs upper bits never affect the amount; in_r only matters in the rotate build
  assign unused_ok = ^{in_r, in_rs[XLEN-1:5]};

  // Stage p0: decode and shift at accept time
  always_comb begin
    kind_p0  = LEFT;
    amt_p0   = in_shamt;
    legal_p0 = 1'b1;
    case (in_funct)
      FUNCT_SLL:  kind_p0 = LEFT;
      FUNCT_SRL:  kind_p0 = RIGHT_LOGICAL;
      FUNCT_SRA:  kind_p0 = RIGHT_ARITH;
      FUNCT_SLLV: begin kind_p0 = LEFT;          amt_p0 = in_rs[4:0]; end
      FUNCT_SRLV: begin kind_p0 = RIGHT_LOGICAL; amt_p0 = in_rs[4:0]; end
      FUNCT_SRAV: begin kind_p0 = RIGHT_ARITH;   amt_p0 = in_rs[4:0]; end
      default:    legal_p0 = 1'b0;
    endcase
`ifdef SHIFT_ROTATE_EN
    if (in_r && (in_funct == FUNCT_SRL || in_funct == FUNCT_SRLV))
      kind_p0 = ROTATE;
`endif
  end

  shift_core #(.XLEN(XLEN)) u_core (
    .data (in_rt),
    .amt  (amt_p0),
    .kind (kind_p0),
    .res  (core_res_p0)
  );

  assign new_p0.res = legal_p0 ? core_res_p0 : '0;
  assign new_p0.rd  = in_rd;
  assign new_p0.ill = ~legal_p0;

  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Stage p1: skid buffer; head feeds EX/MEM, skid catches the op accepted while stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= EMPTY;
      head_p1 <= '0;
      skid_p1 <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            head_p1 <= new_p0;
            state   <= ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            head_p1 <= new_p0;
          end else if (accept) begin
            skid_p1 <= new_p0;
            state   <= TWO;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            head_p1 <= skid_p1;
            state   <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign out_result  = head_p1.res;
  assign out_rd      = head_p1.rd;
  assign out_illegal = head_p1.ill;

endmodule
